// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO between an audio source and the I2S serializer.
// Pairs are popped into a registered staging pair on each serializer load strobe.
module i2s_sample_fifo #(
    parameter int unsigned AW         = 4,
    parameter int unsigned DW         = 24,
    parameter int unsigned UFLOW_HOLD = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_l,
    input  logic [DW-1:0] in_r,
    input  logic          load,
    input  logic          mute,
    input  logic          clr_uflow,
    output logic [DW-1:0] l_data,
    output logic [DW-1:0] r_data,
    output logic [AW:0]   level,
    output logic          uflow
);

    localparam int unsigned Depth     = 1 << AW;
    localparam logic [AW:0] FullLevel = Depth[AW:0];
    localparam logic [AW:0] LevelOne  = {{AW{1'b0}}, 1'b1};

    logic [2*DW-1:0] mem_q [Depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          in_ready_q, in_ready_d;
    logic [DW-1:0] l_data_q, l_data_d;
    logic [DW-1:0] r_data_q, r_data_d;
    logic          uflow_q, uflow_d;

    logic push;
    logic pop;
    logic underrun;

    assign push     = in_valid & in_ready_q;
    assign pop      = load & (level_q != '0);
    assign underrun = load & (level_q == '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        l_data_d   = l_data_q;
        r_data_d   = r_data_q;
        uflow_d    = uflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (mute) begin
                l_data_d = '0;
                r_data_d = '0;
            end else begin
                l_data_d = mem_q[rd_ptr_q][2*DW-1:DW];
                r_data_d = mem_q[rd_ptr_q][DW-1:0];
            end
        end else if (underrun) begin
            // Hold policy keeps the last pair unless muted; otherwise emit silence.
            if ((UFLOW_HOLD == 0) || mute) begin
                l_data_d = '0;
                r_data_d = '0;
            end
        end

        if (push && !pop) begin
            level_d = level_q + LevelOne;
        end else if (!push && pop) begin
            level_d = level_q - LevelOne;
        end

        // Set has priority over clear.
        if (underrun) begin
            uflow_d = 1'b1;
        end else if (clr_uflow) begin
            uflow_d = 1'b0;
        end

        in_ready_d = (level_d != FullLevel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b1;
            l_data_q   <= '0;
            r_data_q   <= '0;
            uflow_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            l_data_q   <= l_data_d;
            r_data_q   <= r_data_d;
            uflow_q    <= uflow_d;
        end
    end

    // Storage needs no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_l, in_r};
        end
    end

    assign in_ready = in_ready_q;
    assign l_data   = l_data_q;
    assign r_data   = r_data_q;
    assign level    = level_q;
    assign uflow    = uflow_q;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Bench for i2s_sample_fifo: zero-policy and hold-policy instances share stimulus
// and are checked against a queue-based model after every clock.
module tb_i2s_sample_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_l = '0;
    logic [23:0] in_r = '0;
    logic        load = 1'b0;
    logic        mute = 1'b0;
    logic        clr_uflow = 1'b0;

    logic        in_ready0, in_ready1;
    logic [23:0] l_data0, r_data0, l_data1, r_data1;
    logic [4:0]  level0, level1;
    logic        uflow0, uflow1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [47:0] mq[$];
    logic [47:0] stage0 = '0;
    logic [47:0] stage1 = '0;
    logic        m_uflow = 1'b0;
    logic        last_load = 1'b0;

    always #5 clk = ~clk;

    i2s_sample_fifo #(.AW(4), .DW(24), .UFLOW_HOLD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_l(in_l), .in_r(in_r), .load(load), .mute(mute), .clr_uflow(clr_uflow),
        .l_data(l_data0), .r_data(r_data0), .level(level0), .uflow(uflow0)
    );

    i2s_sample_fifo #(.AW(4), .DW(24), .UFLOW_HOLD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_l(in_l), .in_r(in_r), .load(load), .mute(mute), .clr_uflow(clr_uflow),
        .l_data(l_data1), .r_data(r_data1), .level(level1), .uflow(uflow1)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [47:0] lvl;
        lvl = 48'(mq.size());
        chk({tag, " level0"}, 48'(level0), lvl);
        chk({tag, " level1"}, 48'(level1), lvl);
        chk({tag, " in_ready0"}, 48'(in_ready0), 48'(mq.size() != 16));
        chk({tag, " in_ready1"}, 48'(in_ready1), 48'(mq.size() != 16));
        chk({tag, " uflow0"}, 48'(uflow0), 48'(m_uflow));
        chk({tag, " uflow1"}, 48'(uflow1), 48'(m_uflow));
        chk({tag, " stage0"}, {l_data0, r_data0}, stage0);
        chk({tag, " stage1"}, {l_data1, r_data1}, stage1);
    endtask

    task automatic model_edge(input logic v, input logic [23:0] l, input logic [23:0] r,
                              input logic ld, input logic m, input logic clr);
        logic        push_ok;
        logic        und;
        logic [47:0] p;
        push_ok = v && (mq.size() != 16);
        und = 1'b0;
        if (ld) begin
            if (mq.size() > 0) begin
                p = mq.pop_front();
                stage0 = m ? 48'h0 : p;
                stage1 = m ? 48'h0 : p;
            end else begin
                und = 1'b1;
                m_uflow = 1'b1;
                stage0 = '0;
                if (m) stage1 = '0;
            end
        end
        if (push_ok) mq.push_back({l, r});
        if (clr && !und) m_uflow = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input string tag, input logic v, input logic [23:0] l,
                        input logic [23:0] r, input logic ld, input logic m, input logic clr);
        in_valid = v; in_l = l; in_r = r; load = ld; mute = m; clr_uflow = clr;
        @(posedge clk);
        model_edge(v, l, r, ld, m, clr);
        @(negedge clk);
        check_all(tag);
        in_valid = 1'b0; load = 1'b0; mute = 1'b0; clr_uflow = 1'b0;
        last_load = ld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        mq.delete();
        stage0 = '0; stage1 = '0; m_uflow = 1'b0; last_load = 1'b0;
        check_all("async_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        step("post_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [23:0] a, b;
        logic        ld;

        // 1: reset
        @(negedge clk);
        do_reset();

        // 2: ordering
        step("push_a", 1'b1, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b0);
        step("push_b", 1'b1, 24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        step("push_c", 1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        idle(63);
        step("load1", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("order1", {l_data0, r_data0}, 48'h000001_800000);
        idle(63);
        step("load2", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("order2", {l_data0, r_data0}, 48'h7FFFFF_FFFFFF);
        idle(63);
        step("load3", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("order3", {l_data0, r_data0}, 48'h123456_ABCDEF);
        idle(63);
        step("load4", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("order4_zero", {l_data0, r_data0}, 48'h0);
        chk("order4_uflow", 48'(uflow0), 48'h1);
        step("clr", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // 3: full
        for (int i = 0; i < 17; i++) begin
            step("fill", 1'b1, 24'(32'h100 + i), 24'(32'h200 + i), 1'b0, 1'b0, 1'b0);
            if (i == 15) chk("full_ready", 48'(in_ready0), 48'h0);
        end
        chk("full_level", 48'(level0), 48'd16);
        step("full_pop", 1'b1, 24'hDEAD00, 24'hBEEF00, 1'b1, 1'b0, 1'b0);
        chk("full_pop_level", 48'(level0), 48'd15);
        chk("full_pop_ready", 48'(in_ready0), 48'h1);
        while (mq.size() > 0) begin
            idle(1);
            step("drain", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end

        // 4: simultaneous push and load at level 5, 40 pairs through to wrap pointers
        for (int i = 0; i < 5; i++)
            step("pre5", 1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("sim", 1'b1, 24'($urandom), 24'($urandom), 1'b1, 1'b0, 1'b0);
            chk("sim_level", 48'(level0), 48'd5);
            idle(1);
        end

        // 5: underrun with hold
        do_reset();
        step("hold_push", 1'b1, 24'h0ABCDE, 24'h054321, 1'b0, 1'b0, 1'b0);
        step("hold_pop", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step("hold_und", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("hold_stage", {l_data1, r_data1}, 48'h0ABCDE_054321);
        chk("hold_uflow", 48'(uflow1), 48'h1);
        step("hold_clr", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("hold_clr_uflow", 48'(uflow1), 48'h0);
        step("und_push", 1'b1, 24'h111111, 24'h222222, 1'b1, 1'b0, 1'b1);
        chk("und_push_level", 48'(level0), 48'd1);

        // 6: mute and mid-stream reset
        step("m_push1", 1'b1, 24'h333333, 24'h444444, 1'b0, 1'b0, 1'b0);
        step("m_push2", 1'b1, 24'h555555, 24'h666666, 1'b0, 1'b0, 1'b0);
        step("mute_load", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("mute_stage", {l_data1, r_data1}, 48'h0);
        chk("mute_level", 48'(level0), 48'd2);
        step("stage_nz", 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step("pop_nz", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #2;
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            ld = !last_load && ($urandom_range(0, 2) == 0);
            step("rand", 1'($urandom_range(0, 1)), a, b, ld,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
